// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared display definitions: scan FSM state encodings and a constant-friendly
// ceil(log2) helper used to size index and counter fields.
package seven_seg_scan_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LIT   = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    function automatic int f_clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/seven_seg_next_digit.sv
// Combinational search for the next enabled digit above the current index,
// wrapping to 0; o_wrap flags that the result is at or below the current index.
module seven_seg_next_digit
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SEL_W      = (NUM_DIGITS > 1) ? f_clog2(NUM_DIGITS) : 1
) (
    input  logic [NUM_DIGITS-1:0] i_mask,
    input  logic [SEL_W-1:0]      i_cur,
    output logic [SEL_W-1:0]      o_next,
    output logic                  o_wrap
);

    logic [SEL_W-1:0] w_idx;
    logic             w_found;

    // Scan cur+1 .. cur+NUM_DIGITS so the current digit itself is the last candidate.
    always_comb begin
        o_next  = i_cur;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_DIGITS; i++) begin
            w_idx = SEL_W'((int'(i_cur) + i) % NUM_DIGITS);
            if (!w_found && i_mask[w_idx]) begin
                w_found = 1'b1;
                o_next  = w_idx;
            end
        end
    end

    assign o_wrap = (o_next <= i_cur);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment anode scanner: lights enabled digits one at a time
// with a programmable dwell and optional blank gap; all outputs are registered.
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int   NUM_DIGITS       = 4,
    parameter int   DWELL_CYCLES     = 1,
    parameter int   BLANK_CYCLES     = 1,
    parameter int   ANODE_ACTIVE_LOW = 1,
    localparam int  SEL_W            = (NUM_DIGITS > 1) ? f_clog2(NUM_DIGITS) : 1
) (
    input  logic                  div_clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [SEL_W-1:0]      digit_sel,
    output logic                  blanking,
    output logic                  frame_start
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = f_clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0]      DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]      BLANK_LOAD = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF  = (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0   = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [SEL_W-1:0]      r_sel;
    logic [NUM_DIGITS-1:0] r_anode;
    logic                  r_blank;
    logic                  r_frame;

    logic [1:0]            w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [SEL_W-1:0]      w_sel_nxt;
    logic                  w_lit_on;
    logic                  w_frame_nxt;
    logic                  w_go_lit;
    logic [NUM_DIGITS-1:0] w_anode_lit;
    logic [SEL_W-1:0]      w_search_cur;
    logic [SEL_W-1:0]      w_next;
    logic                  w_wrap;

    // From IDLE, searching above the top index yields the lowest enabled digit with wrap set.
    assign w_search_cur = (r_state == ST_IDLE) ? SEL_W'(NUM_DIGITS - 1) : r_sel;

    seven_seg_next_digit #(
        .NUM_DIGITS (NUM_DIGITS),
        .SEL_W      (SEL_W)
    ) u_next_digit (
        .i_mask (digit_mask),
        .i_cur  (w_search_cur),
        .o_next (w_next),
        .o_wrap (w_wrap)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_lit_on    = 1'b0;
        w_frame_nxt = 1'b0;
        w_go_lit    = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_go_lit = (digit_mask != '0);
                end
                ST_LIT: begin
                    if (r_cnt == '0 || !digit_mask[r_sel]) begin
                        if (digit_mask == '0) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                        end else if (BLANK_CYCLES == 0) begin
                            w_go_lit = 1'b1;
                        end else begin
                            w_state_nxt = ST_BLANK;
                            w_cnt_nxt   = BLANK_LOAD;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                        w_lit_on  = 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (r_cnt == '0) begin
                        if (digit_mask == '0) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_go_lit = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
            if (w_go_lit) begin
                w_state_nxt = ST_LIT;
                w_cnt_nxt   = DWELL_LOAD;
                w_sel_nxt   = w_next;
                w_lit_on    = 1'b1;
                w_frame_nxt = w_wrap;
            end
        end
    end

    assign w_anode_lit = w_lit_on ? (ONE_HOT0 << w_sel_nxt) : '0;

    always_ff @(posedge div_clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_anode <= ANODE_OFF;
            r_blank <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_anode <= w_anode_lit ^ ANODE_OFF;
            r_blank <= ~w_lit_on;
            r_frame <= w_frame_nxt;
        end
    end

    assign anode       = r_anode;
    assign digit_sel   = r_sel;
    assign blanking    = r_blank;
    assign frame_start = r_frame;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed scoreboard bench for the anode scanner across four parameter sets:
// the driver queues per-cycle expectations, the monitor pops and compares after each edge.
`timescale 1ns/1ps
module tb_seven_seg_scan_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  = 1'b0;
    logic       en   = 1'b0;
    logic [7:0] mask = 8'h00;

    // ---------------- DUTs ----------------
    logic [3:0] an0, an1, an2;
    logic [7:0] an3;
    logic [1:0] sel0, sel1, sel2;
    logic [2:0] sel3;
    logic       bl0, bl1, bl2, bl3;
    logic       fr0, fr1, fr2, fr3;

    seven_seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(1), .BLANK_CYCLES(1), .ANODE_ACTIVE_LOW(1)) u0 (
        .div_clock(clk), .reset(rst), .enable(en), .digit_mask(mask[3:0]),
        .anode(an0), .digit_sel(sel0), .blanking(bl0), .frame_start(fr0));

    seven_seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(1), .BLANK_CYCLES(0), .ANODE_ACTIVE_LOW(1)) u1 (
        .div_clock(clk), .reset(rst), .enable(en), .digit_mask(mask[3:0]),
        .anode(an1), .digit_sel(sel1), .blanking(bl1), .frame_start(fr1));

    seven_seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(3), .BLANK_CYCLES(1), .ANODE_ACTIVE_LOW(1)) u2 (
        .div_clock(clk), .reset(rst), .enable(en), .digit_mask(mask[3:0]),
        .anode(an2), .digit_sel(sel2), .blanking(bl2), .frame_start(fr2));

    seven_seg_scan_ctrl #(.NUM_DIGITS(8), .DWELL_CYCLES(1), .BLANK_CYCLES(1), .ANODE_ACTIVE_LOW(0)) u3 (
        .div_clock(clk), .reset(rst), .enable(en), .digit_mask(mask),
        .anode(an3), .digit_sel(sel3), .blanking(bl3), .frame_start(fr3));

    // Observation word: {anode[7:0], digit_sel[2:0], blanking, frame_start}
    int          dut_sel = 0;
    logic [12:0] obs;
    always_comb begin
        case (dut_sel)
            1:       obs = {4'h0, an1, 1'b0, sel1, bl1, fr1};
            2:       obs = {4'h0, an2, 1'b0, sel2, bl2, fr2};
            3:       obs = {an3, sel3, bl3, fr3};
            default: obs = {4'h0, an0, 1'b0, sel0, bl0, fr0};
        endcase
    end

    // ---------------- scoreboard ----------------
    logic [12:0] exp_q[$];
    string       tag_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    function automatic logic [12:0] pk(input logic [7:0] an, input int sel, input logic bl, input logic fr);
        return {an, 3'(sel), bl, fr};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got anode=%h sel=%0d blank=%b frame=%b, expected anode=%h sel=%0d blank=%b frame=%b",
                     name, act[12:5], act[4:2], act[1], act[0], exp[12:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    // Monitor: the scanner presents a new output every cycle, so pop once per edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                check(tag_q.pop_front(), obs, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Applies inputs for the next edge and queues the outputs expected after it.
    task automatic cyc(input logic r, input logic e, input logic [7:0] m,
                       input logic [7:0] an, input int sel, input logic bl, input logic fr,
                       input string name);
        @(negedge clk);
        rst  = r;
        en   = e;
        mask = m;
        exp_q.push_back(pk(an, sel, bl, fr));
        tag_q.push_back(name);
    endtask

    task automatic phase(input int d);
        @(posedge clk);
        #3;
        dut_sel = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2 rst = 1'b1;
        #1 check("A_rst_async", obs, pk(8'h0F, 0, 1'b1, 1'b0));

        // Default params, full mask: 0,B,1,B,2,B,3,B,0
        cyc(1, 0, 8'h0F, 8'h0F, 0, 1, 0, "A_rst_held");
        cyc(0, 1, 8'h0F, 8'h0E, 0, 0, 1, "A_d0");
        cyc(0, 1, 8'h0F, 8'h0F, 0, 1, 0, "A_b0");
        cyc(0, 1, 8'h0F, 8'h0D, 1, 0, 0, "A_d1");
        cyc(0, 1, 8'h0F, 8'h0F, 1, 1, 0, "A_b1");
        cyc(0, 1, 8'h0F, 8'h0B, 2, 0, 0, "A_d2");
        cyc(0, 1, 8'h0F, 8'h0F, 2, 1, 0, "A_b2");
        cyc(0, 1, 8'h0F, 8'h07, 3, 0, 0, "A_d3");
        cyc(0, 1, 8'h0F, 8'h0F, 3, 1, 0, "A_b3");
        cyc(0, 1, 8'h0F, 8'h0E, 0, 0, 1, "A_d0_wrap");

        // Single enabled digit relights with frame_start; empty mask returns to IDLE
        cyc(0, 1, 8'h04, 8'h0F, 0, 1, 0, "M_blank");
        cyc(0, 1, 8'h04, 8'h0B, 2, 0, 0, "M_d2_first");
        cyc(0, 1, 8'h04, 8'h0F, 2, 1, 0, "M_blank2");
        cyc(0, 1, 8'h04, 8'h0B, 2, 0, 1, "M_relight1");
        cyc(0, 1, 8'h04, 8'h0F, 2, 1, 0, "M_blank3");
        cyc(0, 1, 8'h04, 8'h0B, 2, 0, 1, "M_relight2");
        cyc(0, 1, 8'h00, 8'h0F, 2, 1, 0, "M_idle");
        cyc(0, 1, 8'h00, 8'h0F, 2, 1, 0, "M_idle_stay");

        // enable low forces IDLE at that edge; re-enable restarts at lowest digit
        cyc(0, 1, 8'h0F, 8'h0E, 0, 0, 1, "E_start");
        cyc(0, 0, 8'h0F, 8'h0F, 0, 1, 0, "E_off");
        cyc(0, 1, 8'h0F, 8'h0E, 0, 0, 1, "E_restart");

        // Async reset mid-LIT of digit 3
        cyc(0, 1, 8'h0F, 8'h0F, 0, 1, 0, "R_b0");
        cyc(0, 1, 8'h0F, 8'h0D, 1, 0, 0, "R_d1");
        cyc(0, 1, 8'h0F, 8'h0F, 1, 1, 0, "R_b1");
        cyc(0, 1, 8'h0F, 8'h0B, 2, 0, 0, "R_d2");
        cyc(0, 1, 8'h0F, 8'h0F, 2, 1, 0, "R_b2");
        cyc(0, 1, 8'h0F, 8'h07, 3, 0, 0, "R_d3");
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("R_async", obs, pk(8'h0F, 0, 1'b1, 1'b0));
        cyc(1, 0, 8'h0C, 8'h0F, 0, 1, 0, "R_hold");
        cyc(0, 0, 8'h0C, 8'h0F, 0, 1, 0, "R_idle");
        cyc(0, 1, 8'h0C, 8'h0B, 2, 0, 1, "R_restart");

        // BLANK_CYCLES=0, mask 1010: 1,3,1,3 back to back
        phase(1);
        cyc(1, 0, 8'h0A, 8'h0F, 0, 1, 0, "B_rst");
        cyc(0, 1, 8'h0A, 8'h0D, 1, 0, 1, "B_d1");
        cyc(0, 1, 8'h0A, 8'h07, 3, 0, 0, "B_d3");
        cyc(0, 1, 8'h0A, 8'h0D, 1, 0, 1, "B_d1_again");
        cyc(0, 1, 8'h0A, 8'h07, 3, 0, 0, "B_d3_again");
        cyc(0, 1, 8'h0A, 8'h0D, 1, 0, 1, "B_d1_third");

        // DWELL_CYCLES=3, bit 2 cleared during 2nd dwell cycle of digit 2
        phase(2);
        cyc(1, 0, 8'h0F, 8'h0F, 0, 1, 0, "C_rst");
        cyc(0, 1, 8'h0F, 8'h0E, 0, 0, 1, "C_d0_c1");
        cyc(0, 1, 8'h0F, 8'h0E, 0, 0, 0, "C_d0_c2");
        cyc(0, 1, 8'h0F, 8'h0E, 0, 0, 0, "C_d0_c3");
        cyc(0, 1, 8'h0F, 8'h0F, 0, 1, 0, "C_b0");
        cyc(0, 1, 8'h0F, 8'h0D, 1, 0, 0, "C_d1_c1");
        cyc(0, 1, 8'h0F, 8'h0D, 1, 0, 0, "C_d1_c2");
        cyc(0, 1, 8'h0F, 8'h0D, 1, 0, 0, "C_d1_c3");
        cyc(0, 1, 8'h0F, 8'h0F, 1, 1, 0, "C_b1");
        cyc(0, 1, 8'h0F, 8'h0B, 2, 0, 0, "C_d2_c1");
        cyc(0, 1, 8'h0F, 8'h0B, 2, 0, 0, "C_d2_c2");
        cyc(0, 1, 8'h0B, 8'h0F, 2, 1, 0, "C_d2_cut");
        cyc(0, 1, 8'h0B, 8'h07, 3, 0, 0, "C_d3_c1");
        cyc(0, 1, 8'h0B, 8'h07, 3, 0, 0, "C_d3_c2");
        cyc(0, 1, 8'h0B, 8'h07, 3, 0, 0, "C_d3_c3");
        cyc(0, 1, 8'h0B, 8'h0F, 3, 1, 0, "C_b3");

        // 8 digits, active-high anodes, mask 0x81
        phase(3);
        cyc(1, 0, 8'h81, 8'h00, 0, 1, 0, "D_rst");
        cyc(0, 1, 8'h81, 8'h01, 0, 0, 1, "D_d0");
        cyc(0, 1, 8'h81, 8'h00, 0, 1, 0, "D_b0");
        cyc(0, 1, 8'h81, 8'h80, 7, 0, 0, "D_d7");
        cyc(0, 1, 8'h81, 8'h00, 7, 1, 0, "D_b7");
        cyc(0, 1, 8'h81, 8'h01, 0, 0, 1, "D_d0_wrap");

        // ---------------- report ----------------
        repeat (3) @(posedge clk);
        #3;
        check("queue_drained", 13'(exp_q.size()), 13'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameters SHALL be:
- NUM_DIGITS, 4, number of digits/anodes scanned (2..16).
- DWELL_CYCLES, 1, div_clock cycles each digit stays lit (>=1).
- BLANK_CYCLES, 1, all-off cycles between digits (0 = none).
- ANODE_ACTIVE_LOW, 1, 1 = lit anode driven 0, 0 = lit anode driven 1.
REQ-002 Ports SHALL be:
- div_clock  in  1  scan clock; one clock, all state on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scan run request.
- digit_mask  in  NUM_DIGITS  1 = digit participates in scan.
- anode  out  NUM_DIGITS  one-hot-lit anode drive, polarity per ANODE_ACTIVE_LOW.
- digit_sel  out  clog2(NUM_DIGITS), min 1  index of lit digit, or last lit digit while blank/idle.
- blanking  out  1  high when no anode is lit.
- frame_start  out  1  one-cycle pulse when a new scan frame begins.

Function
REQ-003 Controller SHALL be an FSM with states IDLE, LIT, BLANK; every output SHALL be registered.
REQ-004 At most one anode SHALL be lit in any cycle; in IDLE and BLANK all anodes SHALL be off.
REQ-005 IDLE -> LIT SHALL occur on the first edge with enable=1 and digit_mask nonzero; lit digit = lowest-index set mask bit; frame_start SHALL pulse in that first LIT cycle.
REQ-006 LIT SHALL last exactly DWELL_CYCLES cycles, then go to BLANK for BLANK_CYCLES cycles, or straight to LIT of the next digit when BLANK_CYCLES=0.
REQ-007 Next digit SHALL be the next higher index with mask bit set, wrapping from NUM_DIGITS-1 to 0; mask SHALL be sampled at the decision edge ending LIT/BLANK.
REQ-008 frame_start SHALL pulse in the first LIT cycle of any digit whose index is <= the previously lit index (wrap); with a single enabled digit it SHALL pulse every time that digit relights.
REQ-009 If the lit digit's mask bit clears during LIT, the dwell SHALL end at the next edge (transition per REQ-006).
REQ-010 If digit_mask becomes all-zero, FSM SHALL go to IDLE at the next decision edge and stay there until the mask is nonzero.
REQ-011 enable=0 sampled on any edge SHALL force IDLE at that edge (anodes off the following cycle); re-enable SHALL restart per REQ-005.
REQ-012 Dwell and blank counters SHALL be clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1) bits, reload on every state entry, and never wrap.
REQ-013 blanking SHALL equal 1 exactly when all anodes are off.

Reset
REQ-014 While reset=1, asynchronously: state=IDLE, anode=all off (all 1s if ANODE_ACTIVE_LOW, else all 0s), digit_sel=0, blanking=1, frame_start=0, counters=0.
REQ-015 Reset asserted mid-LIT or mid-BLANK SHALL abort the scan; after release, behaviour SHALL equal power-up.

Structure
REQ-016 The shared display package SHALL hold state encodings (IDLE, LIT, BLANK) and the clog2 width helper.
REQ-017 The next-enabled-digit search (mask, current index -> next index, wrap flag) SHALL be one combinational sub-module, seven_seg_next_digit; the FSM and counters stay in the top module.
REQ-018 Polarity SHALL be applied once, at the anode output register input.

Verification
REQ-019 Default params, mask=4'b1111, enable=1 -> lit pattern 0,B,1,B,2,B,3,B,0 (B = 1-cycle blank); anode while lit = 4'b1110,4'b1101,4'b1011,4'b0111; frame_start on digit-0 cycles only.
REQ-020 mask=4'b1010, BLANK_CYCLES=0 -> digits 1,3,1,3 on consecutive cycles; frame_start each time digit 1 lights; blanking never high after start.
REQ-021 DWELL_CYCLES=3, mask clears bit 2 in 2nd cycle of digit-2 dwell -> digit 2 off next edge, then digit 3 (after blank).
REQ-022 mask=4'b0100 -> digit 2 lit, blank, lit repeatedly; frame_start each relight; mask -> 0 -> IDLE, anode=4'b1111, blanking=1.
REQ-023 Reset asserted asynchronously mid-LIT of digit 3 -> anode=4'b1111, digit_sel=0 without a clock edge; after release + enable, restart at lowest enabled digit with frame_start.
REQ-024 NUM_DIGITS=8, ANODE_ACTIVE_LOW=0, mask=8'h81 -> anode 8'h01, 0, 8'h80, 0, 8'h01; wrap 7->0 flags frame_start.
